// File: rtl/noc_inject_arbiter_pkg.sv
// Shared definitions for the NoC injection-port arbiter: data width, requester limit
// and FSM state type.
package noc_inject_arbiter_pkg;

  localparam int unsigned NocDataWidth    = 32;
  localparam int unsigned NocInjectMaxReq = 8;

  typedef enum logic {
    StIdle,
    StLocked
  } inj_state_e;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, mod N.
// Returns a one-hot grant, its index and whether any request was present.
module noc_rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned SumW = IdxW + 1;

  logic [SumW-1:0] sum;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_o = 1'b0;
    sum     = '0;
    for (int i = 0; i < N; i++) begin
      // ptr_i < N and i < N, so one conditional subtract gives the modulo.
      sum = {1'b0, ptr_i} + SumW'(i);
      if (sum >= SumW'(N)) sum = sum - SumW'(N);
      if (!found_o && req_i[sum[IdxW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = sum[IdxW-1:0];
      end
    end
    if (found_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/noc_inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one NoC injection port between N_REQ
// sources, with a single registered output stage.
module noc_inject_arbiter
  import noc_inject_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned MAX_PKT_FLITS = 16
) (
  input  logic                            noc_clk,
  input  logic                            noc_rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*NocDataWidth-1:0]   req_flit,
  input  logic [N_REQ-1:0]                req_is_header,
  input  logic [N_REQ-1:0]                req_is_tail,
  output logic                            sender_valid,
  input  logic                            sender_ready,
  output logic [NocDataWidth-1:0]         sender_flit,
  output logic                            sender_is_header,
  output logic                            sender_is_tail,
  output logic [$clog2(N_REQ)-1:0]        grant_id,
  output logic                            busy,
  output logic                            proto_err
);

  localparam int unsigned IdxW = $clog2(N_REQ);
  localparam int unsigned CntW = $clog2(MAX_PKT_FLITS + 1);
  localparam int unsigned W    = NocDataWidth;

  inj_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_flit_q, out_flit_d;
  logic            out_hdr_q, out_hdr_d;
  logic            out_tail_q, out_tail_d;

  logic            slot_free, accept, sel_hdr, sel_tail;
  logic [W-1:0]    sel_flit;
  logic [IdxW-1:0] sel_idx;
  logic [N_REQ-1:0] hdr_cand, pick_gnt;
  logic [IdxW-1:0] pick_idx;
  logic            pick_found;
  logic [W-1:0]    flit_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign flit_arr[g] = req_flit[g*W +: W];
  end

  assign hdr_cand = req_valid & req_is_header;

  noc_rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req_i  (hdr_cand),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin : comb_ready
    slot_free = !out_valid_q || sender_ready;
    req_ready = '0;
    sel_idx   = (state_q == StIdle) ? pick_idx : grant_q;
    if (slot_free) begin
      if (state_q == StIdle) begin
        if (pick_found) req_ready = pick_gnt;
      end else begin
        req_ready[grant_q] = 1'b1;
      end
    end
    accept   = |(req_valid & req_ready);
    sel_flit = flit_arr[sel_idx];
    sel_hdr  = req_is_header[sel_idx];
    sel_tail = req_is_tail[sel_idx];
  end

  always_comb begin : comb_next
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_flit_d  = out_flit_q;
    out_hdr_d   = out_hdr_q;
    out_tail_d  = out_tail_q;
    cnt_inc     = (cnt_q == CntW'(MAX_PKT_FLITS)) ? cnt_q : cnt_q + 1'b1;

    // A source offering mid-packet data with no lock held has lost packet framing.
    if (state_q == StIdle && |(req_valid & ~req_is_header)) err_d = 1'b1;

    if (accept) begin
      out_valid_d = 1'b1;
      out_flit_d  = sel_flit;
      out_hdr_d   = sel_hdr;
      out_tail_d  = sel_tail;
      case (state_q)
        StIdle: begin
          grant_d = pick_idx;
          cnt_d   = CntW'(1);
          if (sel_tail) rr_ptr_d = next_idx(pick_idx);
          else          state_d  = StLocked;
        end
        StLocked: begin
          cnt_d = cnt_inc;
          if (sel_hdr) err_d = 1'b1;
          if (sel_tail) begin
            state_d  = StIdle;
            rr_ptr_d = next_idx(grant_q);
          end else if (cnt_inc == CntW'(MAX_PKT_FLITS)) begin
            err_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge noc_clk or posedge noc_rst) begin
    if (noc_rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      out_hdr_q   <= 1'b0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_hdr_q   <= out_hdr_d;
      out_tail_q  <= out_tail_d;
    end
  end

  assign sender_valid     = out_valid_q;
  assign sender_flit      = out_flit_q;
  assign sender_is_header = out_hdr_q;
  assign sender_is_tail   = out_tail_q;
  assign grant_id         = grant_q;
  assign busy             = (state_q == StLocked);
  assign proto_err        = err_q;

endmodule
